// File: rtl/aes_pkg.sv
// Shared AES definitions for the encrypt and decrypt paths.
// Contents: block/word types, FSM state, round count, Rcon, xtime and the forward S-box.
package aes_pkg;

  localparam int NR = 10;

  typedef logic [127:0] aes_block_t;
  typedef logic [31:0]  aes_word_t;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    ROUND = 1'b1
  } aes_state_e;

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[b];
  endfunction

  // Multiply by x in GF(2^8) modulo 0x11b.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] rnd);
    logic [7:0] r;
    case (rnd)
      4'd1:    r = 8'h01;
      4'd2:    r = 8'h02;
      4'd3:    r = 8'h04;
      4'd4:    r = 8'h08;
      4'd5:    r = 8'h10;
      4'd6:    r = 8'h20;
      4'd7:    r = 8'h40;
      4'd8:    r = 8'h80;
      4'd9:    r = 8'h1b;
      4'd10:   r = 8'h36;
      default: r = 8'h00;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/aes_encrypt_if.sv
// Block-level bus of the AES encryptor: operands and start in, result and status out.
interface aes_encrypt_if;
  import aes_pkg::*;

  aes_block_t Plaintext;
  aes_block_t Cipherkey;
  logic       Run;
  aes_block_t Ciphertext;
  logic       Ready;
  logic       Busy;

  modport master (output Plaintext, Cipherkey, Run, input Ciphertext, Ready, Busy);
  modport slave  (input Plaintext, Cipherkey, Run, output Ciphertext, Ready, Busy);
endinterface

// File: rtl/aes_enc_round.sv
// One combinational AES-128 encryption round plus the matching on-the-fly key step.
// Block byte k sits at bits [127-8k -: 8] and is state element s[k%4, k/4].
module aes_enc_round
  import aes_pkg::*;
(
  input  aes_block_t st_i,
  input  aes_block_t rk_i,
  input  logic [7:0] rcon_i,
  input  logic       final_i,
  output aes_block_t st_o,
  output aes_block_t rk_o
);

  logic [7:0] sb_s [16];
  logic [7:0] sr_s [16];
  logic [7:0] mc_s [16];
  aes_word_t  t_s;
  aes_word_t  w0_s;
  aes_word_t  w1_s;
  aes_word_t  w2_s;
  aes_word_t  w3_s;

  // Key step: the next round key depends only on the current one and Rcon.
  assign t_s  = {sbox(rk_i[23:16]), sbox(rk_i[15:8]), sbox(rk_i[7:0]), sbox(rk_i[31:24])}
              ^ {rcon_i, 24'h000000};
  assign w0_s = rk_i[127:96] ^ t_s;
  assign w1_s = rk_i[95:64]  ^ w0_s;
  assign w2_s = rk_i[63:32]  ^ w1_s;
  assign w3_s = rk_i[31:0]   ^ w2_s;
  assign rk_o = {w0_s, w1_s, w2_s, w3_s};

  // SubBytes, ShiftRows (row r rotates left by r) and MixColumns.
  always_comb begin
    sb_s = '{default: 8'h00};
    sr_s = '{default: 8'h00};
    mc_s = '{default: 8'h00};
    for (int k = 0; k < 16; k++) begin
      sb_s[k] = sbox(st_i[127-8*k -: 8]);
    end
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        sr_s[4*c+r] = sb_s[4*((c+r)%4)+r];
      end
    end
    for (int c = 0; c < 4; c++) begin
      mc_s[4*c+0] = xtime(sr_s[4*c+0]) ^ xtime(sr_s[4*c+1]) ^ sr_s[4*c+1] ^ sr_s[4*c+2] ^ sr_s[4*c+3];
      mc_s[4*c+1] = sr_s[4*c+0] ^ xtime(sr_s[4*c+1]) ^ xtime(sr_s[4*c+2]) ^ sr_s[4*c+2] ^ sr_s[4*c+3];
      mc_s[4*c+2] = sr_s[4*c+0] ^ sr_s[4*c+1] ^ xtime(sr_s[4*c+2]) ^ xtime(sr_s[4*c+3]) ^ sr_s[4*c+3];
      mc_s[4*c+3] = xtime(sr_s[4*c+0]) ^ sr_s[4*c+0] ^ sr_s[4*c+1] ^ sr_s[4*c+2] ^ xtime(sr_s[4*c+3]);
    end
  end

  // AddRoundKey with the freshly derived key; the last round bypasses MixColumns.
  always_comb begin
    st_o = '0;
    for (int k = 0; k < 16; k++) begin
      if (final_i) begin
        st_o[127-8*k -: 8] = sr_s[k] ^ rk_o[127-8*k -: 8];
      end else begin
        st_o[127-8*k -: 8] = mc_s[k] ^ rk_o[127-8*k -: 8];
      end
    end
  end

endmodule

// File: rtl/aes_encrypt.sv
// Iterative AES-128 encryptor: whitening on accept, then one round per clock for NR clocks.
// Round keys are derived on the fly from the previous one; no key schedule is stored.
module aes_encrypt
  import aes_pkg::*;
(
  input  logic         Clk,
  input  logic         reset_n,
  aes_encrypt_if.slave bus
);

  aes_state_e state_q, state_d;
  aes_block_t st_q, st_d;
  aes_block_t rk_q, rk_d;
  aes_block_t ct_q, ct_d;
  logic [3:0] rnd_q, rnd_d;
  logic       ready_q, ready_d;

  aes_block_t st_nxt_s;
  aes_block_t rk_nxt_s;
  logic [7:0] rcon_s;
  logic       final_s;

  assign rcon_s  = rcon(rnd_q);
  assign final_s = (rnd_q == 4'(NR));

  aes_enc_round u_round (
    .st_i    (st_q),
    .rk_i    (rk_q),
    .rcon_i  (rcon_s),
    .final_i (final_s),
    .st_o    (st_nxt_s),
    .rk_o    (rk_nxt_s)
  );

  // State and datapath registers.
  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      st_q    <= '0;
      rk_q    <= '0;
      ct_q    <= '0;
      rnd_q   <= 4'd0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      st_q    <= st_d;
      rk_q    <= rk_d;
      ct_q    <= ct_d;
      rnd_q   <= rnd_d;
      ready_q <= ready_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (bus.Run) state_d = ROUND;
        else         state_d = IDLE;
      end
      ROUND: begin
        if (final_s) state_d = IDLE;
        else         state_d = ROUND;
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath next values; Plaintext/Cipherkey/Run only matter in IDLE.
  always_comb begin
    st_d    = st_q;
    rk_d    = rk_q;
    ct_d    = ct_q;
    rnd_d   = rnd_q;
    ready_d = ready_q;
    case (state_q)
      IDLE: begin
        if (bus.Run) begin
          st_d    = bus.Plaintext ^ bus.Cipherkey;
          rk_d    = bus.Cipherkey;
          rnd_d   = 4'd1;
          ready_d = 1'b0;
        end else begin
          ready_d = ready_q;
        end
      end
      ROUND: begin
        st_d = st_nxt_s;
        rk_d = rk_nxt_s;
        if (final_s) begin
          ct_d    = st_nxt_s;
          ready_d = 1'b1;
          rnd_d   = 4'd0;
        end else begin
          rnd_d   = rnd_q + 4'd1;
        end
      end
      default: begin
        rnd_d = 4'd0;
      end
    endcase
  end

  assign bus.Ciphertext = ct_q;
  assign bus.Ready      = ready_q;
  assign bus.Busy       = (state_q == ROUND);

endmodule

// File: tb/tb_aes_encrypt.sv
// Self-checking bench for aes_encrypt: FIPS-197 vectors, control corner cases and random
// blocks against a matrix-form AES model whose S-box is built from GF(2^8) inverses.
module tb_aes_encrypt;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  logic [7:0] sbt  [256];
  logic [7:0] isbt [256];

  logic [127:0] ct;
  logic [127:0] rk1;
  logic [127:0] pt_r;
  logic [127:0] key_r;
  int           lat;

  localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] B_RK1  = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] Z_CT   = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

  aes_encrypt_if bus ();

  aes_encrypt dut (
    .Clk     (clk),
    .reset_n (rst_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    logic [7:0] r;
    r = v;
    for (int i = 0; i < n; i++) r = {r[6:0], r[7]};
    return r;
  endfunction

  function automatic logic [127:0] round_key(input logic [127:0] key, input int n);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {sbt[t[23:16]], sbt[t[15:8]], sbt[t[7:0]], sbt[t[31:24]]} ^ {rc, 24'h000000};
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    return {w[4*n], w[4*n+1], w[4*n+2], w[4*n+3]};
  endfunction

  function automatic logic [127:0] model_enc(input logic [127:0] pt, input logic [127:0] key);
    logic [7:0]   s [4][4];
    logic [7:0]   t [4][4];
    logic [127:0] blk;
    blk = pt ^ round_key(key, 0);
    for (int rnd = 1; rnd <= 10; rnd++) begin
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++) s[r][c] = sbt[blk[127-8*(4*c+r) -: 8]];
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++) t[r][c] = s[r][(c+r)%4];
      if (rnd < 10) begin
        for (int c = 0; c < 4; c++)
          for (int r = 0; r < 4; r++)
            s[r][c] = gmul(8'h02, t[r][c]) ^ gmul(8'h03, t[(r+1)%4][c]) ^ t[(r+2)%4][c] ^ t[(r+3)%4][c];
      end else begin
        s = t;
      end
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++) blk[127-8*(4*c+r) -: 8] = s[r][c];
      blk = blk ^ round_key(key, rnd);
    end
    return blk;
  endfunction

  function automatic logic [127:0] model_dec(input logic [127:0] ctx, input logic [127:0] key);
    logic [7:0]   s [4][4];
    logic [7:0]   t [4][4];
    logic [127:0] blk;
    blk = ctx ^ round_key(key, 10);
    for (int rnd = 9; rnd >= 0; rnd--) begin
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++) s[r][c] = blk[127-8*(4*c+r) -: 8];
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++) t[r][c] = isbt[s[r][(c-r+4)%4]];
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++) blk[127-8*(4*c+r) -: 8] = t[r][c];
      blk = blk ^ round_key(key, rnd);
      if (rnd > 0) begin
        for (int c = 0; c < 4; c++)
          for (int r = 0; r < 4; r++) t[r][c] = blk[127-8*(4*c+r) -: 8];
        for (int c = 0; c < 4; c++)
          for (int r = 0; r < 4; r++)
            blk[127-8*(4*c+r) -: 8] = gmul(8'h0e, t[r][c]) ^ gmul(8'h0b, t[(r+1)%4][c])
                                    ^ gmul(8'h0d, t[(r+2)%4][c]) ^ gmul(8'h09, t[(r+3)%4][c]);
      end
    end
    return blk;
  endfunction

  // ---------------- checking helpers ----------------
  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Accept one block, then wait (bounded) for Ready; optionally scramble inputs while busy.
  task automatic do_run(input logic [127:0] pt, input logic [127:0] key, input bit scramble,
                        output logic [127:0] res, output int latency, output logic [127:0] rk_r1);
    @(negedge clk);
    bus.Plaintext = pt;
    bus.Cipherkey = key;
    bus.Run       = 1'b1;
    @(posedge clk);
    #1;
    bus.Run = 1'b0;
    chk("busy_after_accept", 128'(bus.Busy), 128'd1);
    latency = 0;
    rk_r1   = '0;
    for (int i = 1; i <= 20; i++) begin
      if (scramble) begin
        bus.Plaintext = {$urandom, $urandom, $urandom, $urandom};
        bus.Cipherkey = {$urandom, $urandom, $urandom, $urandom};
        bus.Run       = (i < 9) ? 1'($urandom_range(0, 1)) : 1'b0;
      end
      @(posedge clk);
      #1;
      if (i == 1) rk_r1 = dut.rk_q;
      if (bus.Ready) begin
        latency = i;
        break;
      end
    end
    res = bus.Ciphertext;
    chk("busy_low_at_ready", 128'(bus.Busy), 128'd0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    checks = 0;
    errors = 0;
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv;
      logic [7:0] s;
      inv = 8'h00;
      for (int y = 1; y < 256; y++) if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      s = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
      sbt[x]  = s;
      isbt[s] = 8'(x);
    end

    rst_n         = 1'b0;
    bus.Run       = 1'b1;
    bus.Plaintext = C1_PT;
    bus.Cipherkey = C1_KEY;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_ready", 128'(bus.Ready), 128'd0);
    chk("reset_busy", 128'(bus.Busy), 128'd0);
    chk("reset_ct", bus.Ciphertext, 128'd0);
    chk("reset_rnd", 128'(dut.rnd_q), 128'd0);
    bus.Run = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    do_run(C1_PT, C1_KEY, 1'b0, ct, lat, rk1);
    chk("c1_latency", 128'(lat), 128'd10);
    chk("c1_ct", ct, C1_CT);

    do_run(B_PT, B_KEY, 1'b0, ct, lat, rk1);
    chk("b_rk_round1", rk1, B_RK1);
    chk("b_latency", 128'(lat), 128'd10);
    chk("b_ct", ct, B_CT);
    repeat (3) @(posedge clk);
    #1;
    chk("ready_holds", 128'(bus.Ready), 128'd1);
    chk("ct_holds", bus.Ciphertext, B_CT);

    do_run(128'd0, 128'd0, 1'b1, ct, lat, rk1);
    chk("zero_scrambled_latency", 128'(lat), 128'd10);
    chk("zero_scrambled_ct", ct, Z_CT);

    // Run held high: C.1 then Appendix B back to back.
    @(negedge clk);
    bus.Plaintext = C1_PT;
    bus.Cipherkey = C1_KEY;
    bus.Run       = 1'b1;
    @(posedge clk);
    #1;
    bus.Plaintext = B_PT;
    bus.Cipherkey = B_KEY;
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk);
      #1;
      if (bus.Ready) begin
        lat = i;
        break;
      end
    end
    chk("b2b_first_latency", 128'(lat), 128'd10);
    chk("b2b_first_ct", bus.Ciphertext, C1_CT);
    @(posedge clk);
    #1;
    chk("b2b_ready_one_cycle", 128'(bus.Ready), 128'd0);
    chk("b2b_second_busy", 128'(bus.Busy), 128'd1);
    bus.Run = 1'b0;
    lat = 1;
    for (int i = 2; i <= 21; i++) begin
      @(posedge clk);
      #1;
      if (bus.Ready) begin
        lat = i;
        break;
      end
    end
    chk("b2b_spacing", 128'(lat), 128'd11);
    chk("b2b_second_ct", bus.Ciphertext, B_CT);

    // Reset pulse in the middle of a run.
    @(negedge clk);
    bus.Plaintext = C1_PT;
    bus.Cipherkey = C1_KEY;
    bus.Run       = 1'b1;
    @(posedge clk);
    #1;
    bus.Run = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_ready", 128'(bus.Ready), 128'd0);
    chk("abort_busy", 128'(bus.Busy), 128'd0);
    chk("abort_ct", bus.Ciphertext, 128'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("idle_after_abort", 128'(bus.Busy), 128'd0);
    do_run(C1_PT, C1_KEY, 1'b0, ct, lat, rk1);
    chk("after_abort_latency", 128'(lat), 128'd10);
    chk("after_abort_ct", ct, C1_CT);

    // Random blocks against the model, plus decrypt round trip.
    for (int n = 0; n < 12; n++) begin
      pt_r  = {$urandom, $urandom, $urandom, $urandom};
      key_r = {$urandom, $urandom, $urandom, $urandom};
      do_run(pt_r, key_r, 1'b0, ct, lat, rk1);
      chk("rand_latency", 128'(lat), 128'd10);
      chk("rand_ct", ct, model_enc(pt_r, key_r));
      chk("rand_round_trip", model_dec(ct, key_r), pt_r);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
